// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (Moore).
// A pattern of 1..MAX_LEN bits, its length and an overlap mode are loaded
// with a one-cycle strobe; d_out pulses for one cycle per match and a
// saturating counter tracks matches since the last configuration.
module seq_detector_param #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               d_valid,
  input  logic               d_in,
  output logic               d_out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_MATCH  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] new_hist;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_nxt;
  logic               hit;
  logic               cfg_ok;

  // Candidate history after accepting d_in, and whether it completes a match.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    new_hist = {hist[MAX_LEN-2:0], d_in};
    fill_nxt = (fill == MAX_LEN_L) ? fill : fill + LEN_W'(1);
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_r));
    end
    hit    = (fill_nxt >= len_r) && ((new_hist & len_mask) == (pat_r & len_mask));
    cfg_ok = (pat_len != '0) && (pat_len <= MAX_LEN_L);
  end

  // Single FSM: configuration capture, bit acceptance, match counting.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  // The history register is small and reset like all other state so a
  // fresh configuration never sees stale bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pat_r       <= '0;
      len_r       <= '0;
      ovl_r       <= 1'b0;
      hist        <= '0;
      fill        <= '0;
      match_count <= '0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_load) begin
        // Configuration wins; the same-edge data bit is discarded.
        hist        <= '0;
        fill        <= '0;
        match_count <= '0;
        if (cfg_ok) begin
          pat_r <= pattern;
          len_r <= pat_len;
          ovl_r <= overlap;
          state <= S_SEARCH;
        end else begin
          pat_r   <= '0;
          len_r   <= '0;
          ovl_r   <= 1'b0;
          state   <= S_IDLE;
          cfg_err <= 1'b1;
        end
      end else if (state != S_IDLE) begin
        if (d_valid) begin
          hist <= new_hist;
          if (hit) begin
            state <= S_MATCH;
            // Without overlap, bits before this match cannot feed the next one.
            fill  <= ovl_r ? fill_nxt : '0;
            if (match_count != '1) match_count <= match_count + CNT_W'(1);
          end else begin
            state <= S_SEARCH;
            fill  <= fill_nxt;
          end
        end else begin
          // Gaps hold the partial match; S_MATCH still lasts exactly one cycle.
          state <= S_SEARCH;
        end
      end
    end
  end

  assign d_out = (state == S_MATCH);
  assign armed = (state != S_IDLE);

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param: directed scenarios followed by random
// traffic, checked against a queue-based model of the matching rules.
// Two instances share all inputs: one with an 8-bit counter, one with a
// 2-bit counter to exercise saturation.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               d_valid;
  logic               d_in;

  logic       d_out8, cfg_err8, armed8;
  logic [7:0] count8;
  logic       d_out2, cfg_err2, armed2;
  logic [1:0] count2;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit                 m_cfg;
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  bit                 q[$];
  int                 m_cnt;
  bit                 m_d;
  bit                 m_err;
  bit                 m_cnt_known;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .pattern(pattern),
    .pat_len(pat_len), .overlap(overlap), .d_valid(d_valid), .d_in(d_in),
    .d_out(d_out8), .match_count(count8), .cfg_err(cfg_err8), .armed(armed8)
  );

  seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .pattern(pattern),
    .pat_len(pat_len), .overlap(overlap), .d_valid(d_valid), .d_in(d_in),
    .d_out(d_out2), .match_count(count2), .cfg_err(cfg_err2), .armed(armed2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg = 0; m_pat = '0; m_len = 0; m_ovl = 0; q.delete();
    m_cnt = 0; m_d = 0; m_err = 0; m_cnt_known = 1;
  endtask

  // Matching rules: last len accepted bits equal the pattern (bit 0 = newest).
  task automatic model_edge(input bit c, input logic [MAX_LEN-1:0] p, input int l,
                            input bit o, input bit v, input bit d);
    bit h;
    m_err = 0;
    if (c) begin
      q.delete();
      m_d = 0;
      if (l >= 1 && l <= MAX_LEN) begin
        m_cfg = 1; m_pat = p; m_len = l; m_ovl = o; m_cnt = 0; m_cnt_known = 1;
      end else begin
        m_cfg = 0; m_err = 1; m_cnt_known = 0;
      end
    end else if (m_cfg && v) begin
      q.push_back(d);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      h = (q.size() >= m_len);
      for (int i = 0; i < m_len; i++)
        if (h && q[q.size() - 1 - i] != m_pat[i]) h = 0;
      m_d = h;
      if (h) begin
        m_cnt++;
        if (!m_ovl) q.delete();
      end
    end else begin
      m_d = 0;
    end
  endtask

  task automatic check_all();
    check("d_out8", d_out8, m_d);
    check("d_out2", d_out2, m_d);
    check("armed8", armed8, m_cfg);
    check("armed2", armed2, m_cfg);
    check("cfg_err8", cfg_err8, m_err);
    check("cfg_err2", cfg_err2, m_err);
    if (m_cnt_known) begin
      check("count8", count8, (m_cnt > 255) ? 255 : m_cnt);
      check("count2", count2, (m_cnt > 3) ? 3 : m_cnt);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, sample 1 time unit later.
  task automatic step(input bit c, input logic [MAX_LEN-1:0] p, input int l,
                      input bit o, input bit v, input bit d);
    @(negedge clk);
    cfg_load = c; pattern = p; pat_len = LEN_W'(l); overlap = o; d_valid = v; d_in = d;
    @(posedge clk);
    model_edge(c, p, l, o, v, d);
    #1;
    check_all();
  endtask

  task automatic bit_in(input bit v, input bit d);
    step(0, '0, 0, 0, v, d);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input int l, input bit o);
    step(1, p, l, o, 1, 1);
  endtask

  initial begin
    bit stream7 [7] = '{1, 0, 1, 1, 0, 1, 1};
    rst_n = 0; cfg_load = 0; pattern = '0; pat_len = '0; overlap = 0; d_valid = 0; d_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk) rst_n = 1;

    // 1: unconfigured detector ignores data
    repeat (4) bit_in(1, 1);
    check("t1_count", count8, 0);

    // 2: 1011 with overlap, matches after bits 4 and 7
    load(8'b1011, 4, 1);
    foreach (stream7[i]) begin
      bit_in(1, stream7[i]);
      if (i == 3 || i == 6) check("t2_pulse", d_out8, 1);
    end
    check("t2_count", count8, 2);
    bit_in(0, 0);
    check("t2_drop", d_out8, 0);

    // 3: same stream without overlap, one match only
    load(8'b1011, 4, 0);
    foreach (stream7[i]) bit_in(1, stream7[i]);
    check("t3_count", count8, 1);

    // 4: 11 with overlap on 1111, three back-to-back matches
    load(8'b11, 2, 1);
    repeat (4) bit_in(1, 1);
    check("t4_count", count8, 3);
    bit_in(1, 0);

    // 5: 101 with a long valid gap, then illegal length
    load(8'b101, 3, 0);
    bit_in(1, 1);
    bit_in(1, 0);
    repeat (5) bit_in(0, 1);
    bit_in(1, 1);
    check("t5_pulse", d_out8, 1);
    load(8'b101, 0, 0);
    check("t5_err", cfg_err8, 1);
    check("t5_armed", armed8, 0);
    bit_in(1, 1);
    check("t5_err_clr", cfg_err8, 0);
    load(8'hFF, 9, 1);

    // 6: single-bit pattern, 2-bit counter saturates, then reset mid-pulse
    load(8'b1, 1, 0);
    repeat (5) bit_in(1, 1);
    check("t6_sat2", count2, 3);
    check("t6_cnt8", count8, 5);
    #2 rst_n = 0;
    model_reset();
    #1;
    check("t6_rst_dout", d_out8, 0);
    check_all();
    @(negedge clk) rst_n = 1;

    // Random traffic with occasional reconfiguration
    load(8'b0110, 4, 1);
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        int l;
        if ($urandom_range(0, 7) == 0) l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 15);
        else if ($urandom_range(0, 2) == 0) l = $urandom_range(1, MAX_LEN);
        else l = $urandom_range(1, 3);
        step(1, MAX_LEN'($urandom), l, bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end else begin
        bit_in($urandom_range(0, 3) != 0, bit'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
